// File: rtl/riscv_l1_mem_arbiter.sv
// Purpose: shares one external memory burst port between the icache refill and dcache refill/writeback requesters.
// Latency: request seen in IDLE reaches mem_req next cycle; grant, read beats and write ready pass through combinationally.
// Backpressure: mem_gnt stalls in REQ, mem_rvalid/mem_wready pace beats; bursts are atomic and round-robin between requesters.
module riscv_l1_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  srst_n,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_gnt,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  output logic                  ic_rvalid,
  output logic                  ic_rlast,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [DATA_WIDTH-1:0] dc_wdata,
  output logic                  dc_gnt,
  output logic                  dc_wready,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  output logic                  dc_rvalid,
  output logic                  dc_rlast,
  output logic                  dc_wdone,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_wready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int LB  = BURST_LEN * DATA_WIDTH / 8;
  localparam int OFF = $clog2(LB);
  localparam int CW  = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, REQ, RDATA, WDATA} state_t;

  // owner/last-served encoding: 0 = icache, 1 = dcache
  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  wdone_q, wdone_d;
  logic                  pick_dc;
  logic                  beat_last;

  // dcache wins when alone, or on a tie when icache was served last
  assign pick_dc   = dc_req & (~ic_req | ~last_q);
  assign beat_last = (cnt_q == LAST_BEAT);

  assign mem_req  = (state_q == REQ);
  assign mem_addr = addr_q;
  assign mem_we   = we_q;
  assign dc_wdone = wdone_q;
  // rdata is a plain fan-out; only rvalid qualifies it
  assign ic_rdata = mem_rdata;
  assign dc_rdata = mem_rdata;

  // next-state, arbitration and per-state beat routing
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdone_d   = 1'b0;
    ic_gnt    = 1'b0;
    dc_gnt    = 1'b0;
    ic_rvalid = 1'b0;
    ic_rlast  = 1'b0;
    dc_rvalid = 1'b0;
    dc_rlast  = 1'b0;
    dc_wready = 1'b0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (ic_req | dc_req) begin
          owner_d = pick_dc;
          addr_d  = pick_dc ? {dc_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}}
                            : {ic_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
          we_d    = pick_dc & dc_we;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          ic_gnt  = ~owner_q;
          dc_gnt  = owner_q;
          last_d  = owner_q;
          cnt_d   = '0;
          state_d = we_q ? WDATA : RDATA;
        end
      end
      RDATA: begin
        ic_rvalid = ~owner_q & mem_rvalid;
        dc_rvalid = owner_q & mem_rvalid;
        ic_rlast  = ~owner_q & mem_rvalid & beat_last;
        dc_rlast  = owner_q & mem_rvalid & beat_last;
        if (mem_rvalid) begin
          cnt_d = cnt_q + CW'(1);
          if (beat_last) state_d = IDLE;
        end
      end
      WDATA: begin
        mem_wdata = dc_wdata;
        dc_wready = mem_wready;
        if (mem_wready) begin
          cnt_d = cnt_q + CW'(1);
          if (beat_last) begin
            state_d = IDLE;
            wdone_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; reset aborts any burst and hands the first tie to icache
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdone_q <= wdone_d;
    end
  end

endmodule

// File: doc/riscv_l1_mem_arbiter.md
# riscv_l1_mem_arbiter

Shares the single external memory port between the instruction-cache line-refill requester and the data-cache refill/writeback requester. Performs round-robin arbitration and issues one atomic burst at a time. Routes read beats back to the owner and write beats from the owner. Sits between the L1 caches that feed the fetch and memory stages and the system bus.

## Interface

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 64, beat width in bits; matches the 64-bit fetch packet
- BURST_LEN, 4, beats per line (power of two ≥ 2); line bytes LB = BURST_LEN*DATA_WIDTH/8

Ports (name, direction, width, meaning):
- clk  in  1  clock
- srst_n  in  1  reset, synchronous, active-low
- ic_req  in  1  icache requests a line read
- ic_addr  in  ADDR_WIDTH  icache line address
- ic_gnt  out  1  one-cycle pulse: icache request accepted by memory
- ic_rdata  out  DATA_WIDTH  read beat to icache
- ic_rvalid  out  1  ic_rdata valid
- ic_rlast  out  1  final beat of icache burst
- dc_req  in  1  dcache requests a burst
- dc_we  in  1  1 = line write(back), 0 = line read
- dc_addr  in  ADDR_WIDTH  dcache line address
- dc_wdata  in  DATA_WIDTH  current write beat
- dc_gnt  out  1  one-cycle pulse: dcache request accepted by memory
- dc_wready  out  1  dc_wdata consumed this cycle; dcache advances to next beat
- dc_rdata  out  DATA_WIDTH  read beat to dcache
- dc_rvalid  out  1  dc_rdata valid
- dc_rlast  out  1  final beat of dcache read burst
- dc_wdone  out  1  one-cycle pulse after last write beat accepted
- mem_req  out  1  burst request to memory
- mem_we  out  1  burst direction
- mem_addr  out  ADDR_WIDTH  line-aligned burst address
- mem_gnt  in  1  memory accepts the request this cycle
- mem_wdata  out  DATA_WIDTH  write beat
- mem_wready  in  1  memory consumes mem_wdata this cycle
- mem_rdata  in  DATA_WIDTH  read beat
- mem_rvalid  in  1  mem_rdata valid

## Operation

- States: IDLE, REQ, RDATA, WDATA. Owner register: IC/DC. Last-served pointer: IC/DC. Beat counter: log2(BURST_LEN) bits.
- IDLE arbitration:
  - Only one of ic_req/dc_req: that requester wins.
  - Both: the one not equal to last-served wins.
  - On win: latch owner, mem_addr = {addr[ADDR_WIDTH-1:log2(LB)], zeros}, mem_we = (owner DC) & dc_we; go to REQ.
- REQ: mem_req=1 and mem_addr/mem_we held stable.
  - On mem_gnt: pulse owner's gnt, update last-served, clear counter.
  - Go to WDATA if mem_we, else RDATA.
- RDATA:
  - mem_rdata is routed combinationally to the owner's rdata. Owner's rvalid = mem_rvalid.
  - Counter increments per mem_rvalid. rlast is asserted with the beat where counter = BURST_LEN-1.
  - That beat returns the FSM to IDLE.
- WDATA:
  - mem_wdata = dc_wdata. dc_wready = mem_wready.
  - Counter increments per mem_wready. The last beat returns to IDLE and pulses dc_wdone the next cycle.
- Non-owner valid/ready outputs are always 0. mem_rvalid outside RDATA is ignored. rdata outputs may carry mem_rdata when invalid.
- Bursts are atomic: once latched, a request completes even if its req drops. Requesters hold req until gnt and must not re-request the same line after gnt.
- Counter wrap: the counter wraps to 0 on the last beat.

## Timing

- Reset values: all outputs 0, state IDLE, last-served = DC (icache wins the first tie), counter 0.
- Reset mid-burst: the FSM aborts to IDLE immediately. Memory-side cleanup is the system reset's responsibility.
- Arbitration latency: req sampled in IDLE at edge t → mem_req high from cycle t+1.
- Grant: ic_gnt/dc_gnt are combinational with mem_gnt in REQ. Exactly one pulse per burst.
- Read data: zero added latency; rvalid follows mem_rvalid in the same cycle.
- Back-to-back bursts are separated by exactly one IDLE cycle. A req asserted during a burst is served at the following IDLE.
- Same-cycle ic_req and dc_req in IDLE: resolved by last-served only. The loser waits at most one burst (no starvation).
- mem_gnt asserted the same cycle mem_req rises is legal: the REQ state lasts 1 cycle.

## Test plan

- Reset, then ic_req with ic_addr=0x0000_1234 → mem_req next cycle, mem_addr=0x0000_1220, mem_we=0. mem_gnt → ic_gnt pulse. 4 mem_rvalid beats → 4 ic_rvalid, ic_rlast on beat 4, dc outputs 0.
- ic_req and dc_req (read) both asserted from reset → icache served first, one IDLE cycle, then dcache. Repeat with both held → grants alternate IC, DC, IC, DC.
- dc write to 0x8000_0040 with mem_wready stalled every other cycle → exactly 4 dc_wready pulses matching mem_wready, mem_wdata = dc_wdata, dc_wdone 1 cycle after the 4th.
- mem_rvalid gaps (beats at cycles 1, 4, 5, 9) → rlast only on the 4th beat. Stray mem_rvalid while in IDLE/WDATA produces no rvalid.
- dc_req drops after the latch but before mem_gnt → burst still issues and completes. ic_req pending throughout waits, then is served.
- srst_n low during RDATA beat 2 → next cycle all outputs 0, state IDLE. A new ic_req after reset is granted normally with counter at 0.
